// File: rtl/wb_pkg.sv
// Shared encodings and the write-port bundle for the writeback stage.
package wb_pkg;

  // Native core widths, used by wb_port_t for neighbouring stages.
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  // Source select for the MEM-stage result.
  typedef enum logic [1:0] {
    M2R_ALU  = 2'd0,
    M2R_LOAD = 2'd1,
    M2R_LINK = 2'd2,
    M2R_RSVD = 2'd3
  } mem2reg_e;

  // Load access size; the reserved code behaves as a word load.
  typedef enum logic [1:0] {
    LD_B    = 2'd0,
    LD_H    = 2'd1,
    LD_W    = 2'd2,
    LD_RSVD = 2'd3
  } ld_size_e;

  // Register-file write port at the native core widths.
  typedef struct packed {
    logic                 en;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/wb_lu_fifo.sv
// Long-unit result queue: circular buffer with per-entry valid/kill bits.
// A kill request marks every queued entry (and a same-cycle push) whose
// destination matches, so a newer pipe write is never overwritten by a
// stale long-unit result.
module wb_lu_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              head_kill,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_kill;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  assign wr_idx    = wr_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign head_addr = ent_addr[rd_idx];
  assign head_data = ent_data[rd_idx];
  assign head_kill = ent_kill[rd_idx];

  // Pointer advance; the extra MSB tells full from empty when indices match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage: kill marking first, then pop clear, then push write, so a
  // push into the slot freed by a same-cycle pop (full FIFO) takes effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_kill  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && ent_valid[i] && (ent_addr[i] == kill_addr)) begin
          ent_kill[i] <= 1'b1;
        end
      end
      if (pop) begin
        ent_valid[rd_idx] <= 1'b0;
        ent_kill[rd_idx]  <= 1'b0;
      end
      if (push) begin
        ent_valid[wr_idx] <= 1'b1;
        ent_kill[wr_idx]  <= kill_en && (push_addr == kill_addr);
        ent_addr[wr_idx]  <= push_addr;
        ent_data[wr_idx]  <= push_data;
      end
    end
  end

endmodule

// File: rtl/wb_stage_arb.sv
// Writeback stage: MEM result select (ALU / aligned load / link), and the
// single register-file write port shared between the pipe and a queued
// long-latency unit, with WAW squash and a one-cycle anti-starvation stall.
module wb_stage_arb
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LU_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned PC_INC     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] addrc,
  input  logic [1:0]        mem2reg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] pc,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        byte_off,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic [DATA_W-1:0] data_c,
  output logic [ADDR_W-1:0] addrc_out,
  output logic              reg_wr_w,
  output logic              wb_stall,
  output logic              lu_busy
);

  localparam int unsigned       CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [DATA_W-1:0] LINK_INC   = DATA_W'(PC_INC);

  // Write port at this instance's widths.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } port_t;

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] pipe_data;
  logic              p_fire;
  logic              fifo_pop;
  logic              fifo_push;
  logic              drain_live;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_kill;
  logic [CNT_W-1:0]  starve_cnt;
  port_t             wr_q;

  // Load aligner: pick the addressed byte/half lane and extend it.
  always_comb begin
    byte_lane = mem_out[7:0];
    case (byte_off)
      2'd0:    byte_lane = mem_out[7:0];
      2'd1:    byte_lane = mem_out[15:8];
      2'd2:    byte_lane = mem_out[23:16];
      default: byte_lane = mem_out[31:24];
    endcase
    half_lane = byte_off[1] ? mem_out[31:16] : mem_out[15:0];
    case (ld_size_e'(ld_size))
      LD_B: load_data = ld_signed ? {{(DATA_W-8){byte_lane[7]}}, byte_lane}
                                  : {{(DATA_W-8){1'b0}}, byte_lane};
      LD_H: load_data = ld_signed ? {{(DATA_W-16){half_lane[15]}}, half_lane}
                                  : {{(DATA_W-16){1'b0}}, half_lane};
      default: load_data = mem_out;
    endcase
  end

  // MEM result select; the reserved code writes zero.
  always_comb begin
    case (mem2reg_e'(mem2reg))
      M2R_ALU:  pipe_data = alu_out;
      M2R_LOAD: pipe_data = load_data;
      M2R_LINK: pipe_data = pc + LINK_INC;
      default:  pipe_data = '0;
    endcase
  end

  // Port arbitration: the pipe wins unless stalled; a killed head pops for
  // free every cycle, a live head pops only when the port is idle. A full
  // queue still takes an offered result on a cycle where it pops.
  always_comb begin
    p_fire     = m_valid && reg_wr && (addrc != '0) && !wb_stall;
    drain_live = !fifo_empty && !head_kill && !p_fire;
    fifo_pop   = !fifo_empty && (head_kill || !p_fire);
    fifo_push  = lu_valid && (lu_addr != '0) && (!fifo_full || fifo_pop);
  end

  assign lu_ready  = !fifo_full;
  assign lu_busy   = !fifo_empty;
  assign wb_stall  = (starve_cnt == STARVE_LIM);
  assign reg_wr_w  = wr_q.en;
  assign addrc_out = wr_q.addr;
  assign data_c    = wr_q.data;

  wb_lu_fifo #(
    .DEPTH  (LU_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (fifo_pop),
    .kill_en   (p_fire),
    .kill_addr (addrc),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_kill (head_kill),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Registered write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
    end else if (p_fire) begin
      wr_q <= '{en: 1'b1, addr: addrc, data: pipe_data};
    end else if (drain_live) begin
      wr_q <= '{en: 1'b1, addr: head_addr, data: head_data};
    end else begin
      wr_q.en <= 1'b0;
    end
  end

  // Starvation counter: counts cycles the queue waits, saturating at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
